ecc_tb_checker: RTL
===================

Name: ecc_tb_checker

Overview:
- Scoreboard stage directly downstream of the Hamming decoder in the ECC bench: stimulus -> encoder -> dirty channel -> decoder -> this block.
- Captures reference data word and injected flip count at stimulus time, delays both by the fixed encoder+channel+decoder latency, and checks decoder data and error flags against the expected outcome for 0, 1 or 2 flips.
- Runs a fixed-length test under a small FSM, keeps pass/fail statistics and reports a final verdict.

Parameters:
- K, 4, data word width in bits (decoder output width)
- LATENCY, 3, cycles from valid_i to the matching decoder output; legal range 1..16
- NUM_VECTORS, 256, words accepted per run; legal range >=1
- CNT_W, 16, width of all statistics counters

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle pulse; starts a run from IDLE or DONE
- valid_i  in  1  reference word presented to the encoder this cycle
- data_i  in  K  reference data word
- nflips_i  in  2  flips the channel injects on this word (0,1,2; 3 illegal)
- dec_data_i  in  K  decoder corrected data
- dec_sb_err_i  in  1  decoder single-bit-error (corrected) flag
- dec_db_err_i  in  1  decoder double-bit-error (detected) flag
- busy_o  out  1  state is RUN or DRAIN
- done_o  out  1  state is DONE
- fail_o  out  1  sticky, at least one check failed this run
- checks_o  out  CNT_W  words checked
- errors_o  out  CNT_W  failed checks
- sb_cnt_o  out  CNT_W  checked words with nflips==1
- db_cnt_o  out  CNT_W  checked words with nflips==2
- first_err_o  out  CNT_W  checks_o value at first failure; all-ones if none

Behaviour:
- Reset (async, rst_ni low): state IDLE; delay line valid bits 0; busy_o=0, done_o=0, fail_o=0; all counters 0; first_err_o all-ones.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start_i -> RUN; same edge clears counters, fail_o, first_err_o (all-ones), delay line, issue counter. start_i in RUN/DRAIN ignored.
- RUN: each valid_i=1 enters {data_i, nflips_i} into the delay line and increments issue count. When the NUM_VECTORS-th word enters -> DRAIN next cycle.
- DRAIN: valid_i ignored (not entered). When checks_o reaches NUM_VECTORS -> DONE; no pending valid remains.
- DONE: holds all outputs stable until start_i.
- Delay line: LATENCY-stage shift register, shifts every cycle; a valid slot exits exactly LATENCY cycles after entry. Back-to-back and gapped valid both supported.
- Check on an exiting valid slot, expectation by nflips:
  - 0: dec_data_i==data, sb=0, db=0
  - 1: dec_data_i==data, sb=1, db=0
  - 2: sb=0, db=1; dec_data_i not compared
  - 3: always a failure
- Per check: checks_o+1; sb_cnt_o/db_cnt_o +1 per class; on failure errors_o+1, fail_o<=1, and if first_err_o is all-ones, first_err_o<=checks_o (pre-increment value).
- Counters saturate at all-ones; no wrap.
- Exiting valid slots in IDLE/DONE are discarded uncounted (not possible after a clean run).
- Reset mid-run: all state to reset values immediately; no partial statistics retained.

Test Plan:
- K=4, LATENCY=3, NUM_VECTORS=8; 8 back-to-back words nflips=0, decoder returns exact data, no flags -> done_o 3 cycles after last valid; checks_o=8, errors_o=0, fail_o=0, first_err_o=16'hFFFF.
- 8 words nflips=1, decoder data correct, sb=1 -> sb_cnt_o=8, db_cnt_o=0, errors_o=0.
- Words 0..7 with nflips=2 on index 5 only, decoder asserts db on index 5 and returns garbage data -> errors_o=0, db_cnt_o=1.
- Decoder returns data^4'h1 on check index 3 (nflips=0) -> errors_o=1, fail_o=1, first_err_o=3; second failure at index 6 leaves first_err_o=3, errors_o=2.
- Valid with 2-cycle gaps plus valid_i held high during DRAIN -> exactly 8 checks, extra words ignored; nflips_i=3 on one word -> errors_o=1.
- rst_ni low for 1 cycle mid-RUN after 4 words -> outputs reset asynchronously, state IDLE; new start_i gives a clean 8-word run.

Source files
------------

// File: rtl/ecc_tb_checker.sv
// Scoreboard behind the Hamming decoder: delays each reference word and flip count
// by the fixed pipeline latency and checks decoder data/flags, keeping run statistics.
module ecc_tb_checker #(
  parameter int K           = 4,
  parameter int LATENCY     = 3,
  parameter int NUM_VECTORS = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [K-1:0]     data_i,
  input  logic [1:0]       nflips_i,
  input  logic [K-1:0]     dec_data_i,
  input  logic             dec_sb_err_i,
  input  logic             dec_db_err_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] checks_o,
  output logic [CNT_W-1:0] errors_o,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o,
  output logic [CNT_W-1:0] first_err_o
);

  localparam int ISSUE_W = $clog2(NUM_VECTORS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_reg;
  logic               busy_reg, done_reg, fail_reg;
  logic [CNT_W-1:0]   checks_reg, errors_reg, sb_cnt_reg, db_cnt_reg, first_err_reg;
  logic [ISSUE_W-1:0] issue_reg;

  logic               start_go;
  logic               dl_entry;
  logic               exit_valid;
  logic [K-1:0]       exit_data;
  logic [1:0]         exit_nf;
  logic               check_en;
  logic               check_fail;
  logic [CNT_W-1:0]   checks_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign start_go = start_i && (state_reg == S_IDLE || state_reg == S_DONE);
  assign dl_entry = valid_i && (state_reg == S_RUN);

  // Delay line: stage 0 loads on entry, last stage lines up with the decoder output.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic         valid_reg;
    logic [K-1:0] data_reg;
    logic [1:0]   nf_reg;
    logic         valid_in;
    logic [K-1:0] data_in;
    logic [1:0]   nf_in;

    if (gi == 0) begin : g_head
      assign valid_in = dl_entry;
      assign data_in  = data_i;
      assign nf_in    = nflips_i;
    end else begin : g_tail
      assign valid_in = g_stage[gi-1].valid_reg;
      assign data_in  = g_stage[gi-1].data_reg;
      assign nf_in    = g_stage[gi-1].nf_reg;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        nf_reg    <= '0;
      end else if (start_go) begin
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= valid_in;
        data_reg  <= data_in;
        nf_reg    <= nf_in;
      end
    end
  end

  assign exit_valid = g_stage[LATENCY-1].valid_reg;
  assign exit_data  = g_stage[LATENCY-1].data_reg;
  assign exit_nf    = g_stage[LATENCY-1].nf_reg;

  assign check_en    = exit_valid && (state_reg == S_RUN || state_reg == S_DRAIN);
  assign checks_next = check_en ? sat_inc(checks_reg) : checks_reg;

  // Two flips are only required to be detected, so the data is left uncompared.
  always_comb begin
    check_fail = 1'b1;
    case (exit_nf)
      2'd0:    check_fail = (dec_data_i != exit_data) || dec_sb_err_i || dec_db_err_i;
      2'd1:    check_fail = (dec_data_i != exit_data) || !dec_sb_err_i || dec_db_err_i;
      2'd2:    check_fail = dec_sb_err_i || !dec_db_err_i;
      default: check_fail = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= S_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      checks_reg    <= '0;
      errors_reg    <= '0;
      sb_cnt_reg    <= '0;
      db_cnt_reg    <= '0;
      first_err_reg <= '1;
      issue_reg     <= '0;
    end else begin
      if (check_en) begin
        checks_reg <= sat_inc(checks_reg);
        if (exit_nf == 2'd1) sb_cnt_reg <= sat_inc(sb_cnt_reg);
        if (exit_nf == 2'd2) db_cnt_reg <= sat_inc(db_cnt_reg);
        if (check_fail) begin
          errors_reg <= sat_inc(errors_reg);
          fail_reg   <= 1'b1;
          if (&first_err_reg) first_err_reg <= checks_reg;
        end
      end

      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_reg     <= S_RUN;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
            checks_reg    <= '0;
            errors_reg    <= '0;
            sb_cnt_reg    <= '0;
            db_cnt_reg    <= '0;
            first_err_reg <= '1;
            issue_reg     <= '0;
          end
        end
        S_RUN: begin
          if (valid_i) begin
            issue_reg <= issue_reg + ISSUE_W'(1);
            if (issue_reg == ISSUE_W'(NUM_VECTORS - 1)) state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (checks_next >= CNT_W'(NUM_VECTORS)) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign fail_o      = fail_reg;
  assign checks_o    = checks_reg;
  assign errors_o    = errors_reg;
  assign sb_cnt_o    = sb_cnt_reg;
  assign db_cnt_o    = db_cnt_reg;
  assign first_err_o = first_err_reg;

endmodule
